// File: rtl/bullet_motion_ctrl.sv
// Bullet trajectory stage: launches a bullet from the ship X, steps it upward once per
// movement tick, clamps it at the retire row and pulses hit on target overlap.
module bullet_motion_ctrl #(
  parameter int unsigned START_Y  = 440,
  parameter int unsigned TOP_Y    = 66,
  parameter int unsigned STEP     = 4,
  parameter int unsigned TICK_DIV = 250000,
  parameter int unsigned BULLET_W = 4,
  parameter int unsigned BULLET_H = 8,
  parameter int unsigned TARGET_W = 32,
  parameter int unsigned TARGET_H = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic [9:0] shipPosX,
  input  logic [9:0] targetPosX,
  input  logic [9:0] targetPosY,
  output logic [9:0] bulletPosX,
  output logic [9:0] bulletPosY,
  output logic       bulletActive,
  output logic       hit
);

  localparam int unsigned    CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [9:0]     START_V  = 10'(START_Y);
  localparam logic [9:0]     TOP_V    = 10'(TOP_Y);
  localparam logic [10:0]    TOP_W    = 11'(TOP_Y);
  localparam logic [10:0]    STEP_W   = 11'(STEP);
  localparam logic [10:0]    BW_W     = 11'(BULLET_W);
  localparam logic [10:0]    BH_W     = 11'(BULLET_H);
  localparam logic [10:0]    TW_W     = 11'(TARGET_W);
  localparam logic [10:0]    TH_W     = 11'(TARGET_H);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_FLY, S_RETIRE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [9:0]         bx_q, bx_d;
  logic [9:0]         by_q, by_d;
  logic               active_q, active_d;
  logic               hit_q, hit_d;

  logic [10:0]        ny;
  logic               tick;
  logic               overlap;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bx_d     = bx_q;
    by_d     = by_q;
    active_d = active_q;
    hit_d    = 1'b0;

    // Candidate next row, widened so the top-row compare cannot wrap.
    ny      = {1'b0, by_q} - STEP_W;
    tick    = (cnt_q == CNT_LAST);
    overlap = (({1'b0, bx_q} + BW_W) > {1'b0, targetPosX}) &&
              ({1'b0, bx_q} < ({1'b0, targetPosX} + TW_W)) &&
              (ny < ({1'b0, targetPosY} + TH_W)) &&
              ((ny + BH_W) > {1'b0, targetPosY});

    case (state_q)
      S_IDLE: begin
        by_d     = START_V;
        cnt_d    = '0;
        active_d = 1'b0;
        if (enb) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        bx_d     = shipPosX;
        active_d = 1'b1;
        cnt_d    = '0;
        state_d  = S_FLY;
      end
      S_FLY: begin
        if (tick) begin
          cnt_d = '0;
          if (overlap) begin
            hit_d   = 1'b1;
            by_d    = TOP_V;
            state_d = S_RETIRE;
          end else if ($signed(ny) <= $signed(TOP_W)) begin
            by_d    = TOP_V;
            state_d = S_RETIRE;
          end else begin
            by_d = ny[9:0];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RETIRE: begin
        by_d     = TOP_V;
        active_d = 1'b0;
        if (!enb) begin
          state_d = S_IDLE;
          by_d    = START_V;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bx_q     <= '0;
      by_q     <= START_V;
      active_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      active_q <= active_d;
      hit_q    <= hit_d;
    end
  end

  assign bulletPosX   = bx_q;
  assign bulletPosY   = by_q;
  assign bulletActive = active_q;
  assign hit          = hit_q;

endmodule

// File: tb/tb_bullet_motion_ctrl.sv
// Bench for bullet_motion_ctrl: hand-computed flight table, reset/abort sequences and
// randomized flights checked against a trajectory predictor.
module tb_bullet_motion_ctrl;

  localparam int START_Y  = 100;
  localparam int TOP_Y    = 66;
  localparam int STEP     = 4;
  localparam int TICK_DIV = 4;
  localparam int BULLET_W = 4;
  localparam int BULLET_H = 8;
  localparam int TARGET_W = 32;
  localparam int TARGET_H = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic [9:0] shipPosX;
  logic [9:0] targetPosX;
  logic [9:0] targetPosY;
  logic [9:0] bulletPosX;
  logic [9:0] bulletPosY;
  logic       bulletActive;
  logic       hit;

  bullet_motion_ctrl #(
    .START_Y (START_Y),
    .TOP_Y   (TOP_Y),
    .STEP    (STEP),
    .TICK_DIV(TICK_DIV),
    .BULLET_W(BULLET_W),
    .BULLET_H(BULLET_H),
    .TARGET_W(TARGET_W),
    .TARGET_H(TARGET_H)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enb         (enb),
    .shipPosX    (shipPosX),
    .targetPosX  (targetPosX),
    .targetPosY  (targetPosY),
    .bulletPosX  (bulletPosX),
    .bulletPosY  (bulletPosY),
    .bulletActive(bulletActive),
    .hit         (hit)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  int exp_ys[$];
  bit exp_hit;

  typedef struct {
    int sx;
    int tx;
    int ty;
    int hits;
    int moves;
  } vec_t;

  vec_t tbl[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Whole-flight prediction: list of rows the bullet lands on, one per tick.
  task automatic predict(input int sx, input int tx, input int ty);
    int y;
    int ny;
    exp_ys.delete();
    exp_hit = 1'b0;
    y = START_Y;
    for (int k = 0; k < 1024; k++) begin
      ny = y - STEP;
      if ((sx + BULLET_W > tx) && (sx < tx + TARGET_W) &&
          (ny < ty + TARGET_H) && (ny + BULLET_H > ty)) begin
        exp_hit = 1'b1;
        exp_ys.push_back(TOP_Y);
        break;
      end else if (ny <= TOP_Y) begin
        exp_ys.push_back(TOP_Y);
        break;
      end
      exp_ys.push_back(ny);
      y = ny;
    end
  endtask

  // Starts from IDLE with enb low; leaves the DUT in IDLE with enb low.
  task automatic fly(input int sx, input int tx, input int ty, input bit drop_mid,
                     input bit move_ship, output int obs_moves, output int obs_hits);
    int prev_y;
    int last_obs;
    int last_k;
    int exp_y;
    predict(sx, tx, ty);
    last_k    = exp_ys.size() - 1;
    obs_moves = 0;
    obs_hits  = 0;
    shipPosX   = 10'(sx);
    targetPosX = 10'(tx);
    targetPosY = 10'(ty);
    enb        = 1'b1;
    step();
    check("launch_posy", int'(bulletPosY), START_Y);
    step();
    check("fly_posx", int'(bulletPosX), sx);
    check("fly_active", int'(bulletActive), 1);
    if (move_ship) shipPosX = 10'(50);
    if (drop_mid) enb = 1'b0;
    prev_y   = START_Y;
    last_obs = int'(bulletPosY);
    for (int k = 0; k <= last_k; k++) begin
      for (int c = 1; c <= TICK_DIV; c++) begin
        step();
        if (int'(bulletPosY) != last_obs) obs_moves++;
        last_obs = int'(bulletPosY);
        if (hit) obs_hits++;
        exp_y = (c == TICK_DIV) ? exp_ys[k] : prev_y;
        check("fly_posy", int'(bulletPosY), exp_y);
        check("fly_hit", int'(hit), (c == TICK_DIV && k == last_k && exp_hit) ? 1 : 0);
        if (c == 1) check("fly_active_hold", int'(bulletActive), 1);
      end
      check("fly_posx_hold", int'(bulletPosX), sx);
      prev_y = exp_ys[k];
    end
    step();
    if (hit) obs_hits++;
    check("retire_hit_clear", int'(hit), 0);
    check("retire_posy", int'(bulletPosY), enb ? TOP_Y : START_Y);
    step();
    if (hit) obs_hits++;
    check("retire_active", int'(bulletActive), 0);
    check("retire_posy2", int'(bulletPosY), enb ? TOP_Y : START_Y);
    if (enb) begin
      for (int h = 0; h < 2; h++) begin
        step();
        if (hit) obs_hits++;
        check("retire_hold_posy", int'(bulletPosY), TOP_Y);
        check("retire_hold_hit", int'(hit), 0);
      end
    end
    enb = 1'b0;
    step();
    check("idle_posy", int'(bulletPosY), START_Y);
    check("idle_active", int'(bulletActive), 0);
  endtask

  initial begin
    int m;
    int h;
    int sx;
    int tx;
    int ty;
    bit dr;
    bit mv;

    tbl[0]  = '{sx: 200, tx: 300, ty: 70,  hits: 0, moves: 9};
    tbl[1]  = '{sx: 200, tx: 190, ty: 70,  hits: 1, moves: 4};
    tbl[2]  = '{sx: 200, tx: 204, ty: 70,  hits: 0, moves: 9};
    tbl[3]  = '{sx: 200, tx: 203, ty: 70,  hits: 1, moves: 4};
    tbl[4]  = '{sx: 200, tx: 168, ty: 70,  hits: 0, moves: 9};
    tbl[5]  = '{sx: 200, tx: 169, ty: 70,  hits: 1, moves: 4};
    tbl[6]  = '{sx: 200, tx: 190, ty: 58,  hits: 1, moves: 7};
    tbl[7]  = '{sx: 200, tx: 190, ty: 56,  hits: 1, moves: 8};
    tbl[8]  = '{sx: 200, tx: 190, ty: 52,  hits: 1, moves: 9};
    tbl[9]  = '{sx: 200, tx: 190, ty: 48,  hits: 0, moves: 9};
    tbl[10] = '{sx: 200, tx: 190, ty: 100, hits: 1, moves: 1};
    tbl[11] = '{sx: 200, tx: 190, ty: 104, hits: 0, moves: 9};

    rst        = 1'b1;
    enb        = 1'b0;
    shipPosX   = '0;
    targetPosX = '0;
    targetPosY = '0;
    step();
    step();
    check("rst_posy", int'(bulletPosY), START_Y);
    check("rst_posx", int'(bulletPosX), 0);
    check("rst_active", int'(bulletActive), 0);
    check("rst_hit", int'(hit), 0);
    rst = 1'b0;
    step();
    check("idle0_posy", int'(bulletPosY), START_Y);

    for (int i = 0; i < 12; i++) begin
      fly(tbl[i].sx, tbl[i].tx, tbl[i].ty, 1'b0, 1'b0, m, h);
      check("tbl_moves", m, tbl[i].moves);
      check("tbl_hits", h, tbl[i].hits);
    end

    // enb dropped and ship moved mid-flight: flight still completes from X=200
    fly(200, 300, 70, 1'b1, 1'b1, m, h);
    check("abort_moves", m, 9);
    check("abort_hits", h, 0);

    // Reset landing exactly on the tick that would have produced a hit
    shipPosX   = 10'(200);
    targetPosX = 10'(190);
    targetPosY = 10'(90);
    enb        = 1'b1;
    step();
    step();
    step();
    step();
    step();
    rst = 1'b1;
    step();
    check("midrst_hit", int'(hit), 0);
    check("midrst_posy", int'(bulletPosY), START_Y);
    check("midrst_posx", int'(bulletPosX), 0);
    check("midrst_active", int'(bulletActive), 0);
    step();
    check("midrst_posy2", int'(bulletPosY), START_Y);
    rst = 1'b0;
    enb = 1'b0;
    step();
    check("postrst_posy", int'(bulletPosY), START_Y);
    check("postrst_active", int'(bulletActive), 0);

    for (int r = 0; r < 25; r++) begin
      sx = int'($urandom_range(0, 1023));
      tx = sx + int'($urandom_range(0, 80)) - 40;
      if (tx < 0) tx = 0;
      if (tx > 1023) tx = 1023;
      ty = int'($urandom_range(40, 120));
      dr = 1'($urandom_range(0, 1));
      mv = 1'($urandom_range(0, 1));
      fly(sx, tx, ty, dr, mv, m, h);
      check("rnd_moves", m, exp_ys.size());
      check("rnd_hits", h, exp_hit ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
